// File: rtl/mode_controller.sv
// Turns three debounced active-low buttons and an auto-cycle switch into the
// registered 4-bit mode code (OFF, M1..M4) for the LED pattern selector.
module mode_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_PERIOD     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_next_n,
  input  logic       key_prev_n,
  input  logic       key_off_n,
  input  logic       auto_en,
  output logic [3:0] mode_select,
  output logic       mode_changed
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(AUTO_PERIOD);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] AP_MAX = TW'(AUTO_PERIOD - 1);

  localparam int K_NEXT = 0;
  localparam int K_PREV = 1;
  localparam int K_OFF  = 2;

  typedef enum logic [3:0] {
    M_OFF = 4'b0000,
    M_1   = 4'b0001,
    M_2   = 4'b0010,
    M_3   = 4'b0011,
    M_4   = 4'b0100
  } mode_t;

  logic [2:0]    key_s1, key_s2;
  logic          auto_s1, auto_s2;
  logic [2:0]    key_db, key_db_d, key_evt;
  logic [DW-1:0] db_cnt [3];
  logic [TW-1:0] timer;
  mode_t         mode_q, mode_nxt;
  logic          tick, key_any, timer_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1  <= '1;
      key_s2  <= '1;
      auto_s1 <= 1'b0;
      auto_s2 <= 1'b0;
    end else begin
      key_s1  <= {key_off_n, key_prev_n, key_next_n};
      key_s2  <= key_s1;
      auto_s1 <= auto_en;
      auto_s2 <= auto_s1;
    end
  end

  // A new level is accepted only after it has differed from the debounced
  // state for DEBOUNCE_CYCLES consecutive cycles; any return clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_db   <= '1;
      key_db_d <= '1;
      key_evt  <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (key_s2[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          key_db[i] <= key_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      key_db_d <= key_db;
      key_evt  <= key_db_d & ~key_db;
    end
  end

  function automatic mode_t adv_next(input mode_t m);
    case (m)
      M_OFF:   return M_1;
      M_1:     return M_2;
      M_2:     return M_3;
      M_3:     return M_4;
      M_4:     return M_1;
      default: return M_OFF;
    endcase
  endfunction

  function automatic mode_t adv_prev(input mode_t m);
    case (m)
      M_OFF:   return M_4;
      M_4:     return M_3;
      M_3:     return M_2;
      M_2:     return M_1;
      M_1:     return M_4;
      default: return M_OFF;
    endcase
  endfunction

  always_comb begin
    mode_nxt = mode_q;
    key_any  = |key_evt;
    tick     = auto_s2 && (mode_q != M_OFF) && (timer == AP_MAX);
    if (!(mode_q inside {M_OFF, M_1, M_2, M_3, M_4}))
      mode_nxt = M_OFF;
    else if (key_evt[K_OFF])
      mode_nxt = M_OFF;
    else if (key_evt[K_NEXT] && key_evt[K_PREV])
      mode_nxt = mode_q;
    else if (key_evt[K_NEXT])
      mode_nxt = adv_next(mode_q);
    else if (key_evt[K_PREV])
      mode_nxt = adv_prev(mode_q);
    else if (tick)
      mode_nxt = adv_next(mode_q);
    // Key events win over a coincident tick because they are checked first.
    timer_clr = !auto_s2 || (mode_q == M_OFF) || key_any || tick
                || (mode_nxt != mode_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= M_OFF;
      mode_changed <= 1'b0;
      timer        <= '0;
    end else begin
      mode_q       <= mode_nxt;
      mode_changed <= (mode_nxt != mode_q);
      timer        <= timer_clr ? '0 : timer + 1'b1;
    end
  end

  assign mode_select = mode_q;

endmodule

// File: tb/tb_mode_controller.sv
// Directed bench for mode_controller: stimulus pushes {cycle, mode} expectations,
// a negedge monitor pops one per mode_changed pulse and checks value and timing.
module tb_mode_controller;

  localparam int DB  = 8;
  localparam int AP  = 20;
  localparam int LAT = DB + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_next_n = 1'b1;
  logic       key_prev_n = 1'b1;
  logic       key_off_n = 1'b1;
  logic       auto_en = 1'b0;
  logic [3:0] mode_select;
  logic       mode_changed;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [35:0] exp_q[$];
  logic [35:0] mon_e;
  logic [3:0]  prev_mode = 4'b0000;
  logic [3:0]  next_seq [5] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0001};
  int          c0;

  mode_controller #(.DEBOUNCE_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_next_n   (key_next_n),
    .key_prev_n   (key_prev_n),
    .key_off_n    (key_off_n),
    .auto_en      (auto_en),
    .mode_select  (mode_select),
    .mode_changed (mode_changed)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // driver tasks: inputs change 2 time units after a rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input int k, input logic v);
    case (k)
      0:       key_next_n = v;
      1:       key_prev_n = v;
      default: key_off_n  = v;
    endcase
  endtask

  task automatic expect_mode(input int at, input logic [3:0] m);
    exp_q.push_back({32'(at), m});
  endtask

  task automatic press(input int k, input int hold, input int rest,
                       input logic [3:0] m, input bit want);
    if (want) expect_mode(cyc + LAT, m);
    drive(k, 1'b0);
    step(hold);
    drive(k, 1'b1);
    step(rest);
  endtask

  task automatic check_now(input string name, input logic [3:0] m);
    checks++;
    if (mode_select !== m) begin
      failures++;
      $display("FAIL %s: mode_select=%b expected %b at cycle %0d", name, mode_select, m, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (mode_select !== 4'b0000 || mode_changed !== 1'b0) begin
        failures++;
        $display("FAIL reset_state: mode_select=%b mode_changed=%b expected 0000/0", mode_select, mode_changed);
      end
    end else begin
      if (mode_changed === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: mode_select=%b at cycle %0d, none expected", mode_select, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mode_select !== mon_e[3:0] || cyc !== int'(mon_e[35:4])) begin
            failures++;
            $display("FAIL step: mode_select=%b at cycle %0d, expected %b at cycle %0d",
                     mode_select, cyc, mon_e[3:0], int'(mon_e[35:4]));
          end
        end
      end
      if (mode_select !== prev_mode) begin
        checks++;
        if (mode_changed !== 1'b1) begin
          failures++;
          $display("FAIL silent_change: mode_select %b->%b with mode_changed=%b", prev_mode, mode_select, mode_changed);
        end
      end
    end
    prev_mode = mode_select;
  end

  initial begin
    step(3);
    rst_n = 1'b1;
    step(100);
    check_now("idle_off", 4'b0000);

    for (int i = 0; i < 5; i++) press(0, 30, 30, next_seq[i], 1'b1);
    press(2, 30, 30, 4'b0000, 1'b1);

    // short bounce on prev is ignored, then a clean press from OFF wraps to M4
    drive(1, 1'b0);
    step(5);
    drive(1, 1'b1);
    step(10);
    press(1, 30, 30, 4'b0100, 1'b1);

    press(0, 30, 30, 4'b0001, 1'b1);
    press(0, 30, 30, 4'b0010, 1'b1);
    c0 = cyc;
    auto_en = 1'b1;
    expect_mode(c0 + AP + 2, 4'b0011);
    expect_mode(c0 + 2 * AP + 2, 4'b0100);
    expect_mode(c0 + 3 * AP + 2, 4'b0001);
    step(3 * AP + 5);
    auto_en = 1'b0;
    step(20);
    check_now("auto_stop", 4'b0001);

    press(2, 30, 30, 4'b0000, 1'b1);
    auto_en = 1'b1;
    step(200);
    check_now("auto_in_off", 4'b0000);
    auto_en = 1'b0;
    step(5);

    press(1, 30, 30, 4'b0100, 1'b1);
    press(1, 30, 30, 4'b0011, 1'b1);
    key_next_n = 1'b0;
    key_prev_n = 1'b0;
    step(30);
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    step(30);
    check_now("collision", 4'b0011);

    expect_mode(cyc + LAT, 4'b0000);
    key_off_n  = 1'b0;
    key_next_n = 1'b0;
    step(30);
    key_off_n  = 1'b1;
    key_next_n = 1'b1;
    step(30);

    // reset in the middle of a debounce, key still held after release
    press(0, 30, 30, 4'b0001, 1'b1);
    key_next_n = 1'b0;
    step(4);
    rst_n = 1'b0;
    step(4);
    check_now("in_reset", 4'b0000);
    rst_n = 1'b1;
    expect_mode(cyc + LAT, 4'b0001);
    step(30);
    key_next_n = 1'b1;
    step(30);
    check_now("after_reset", 4'b0001);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending: %0d expected steps never seen, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
